// File: rtl/mem_access_arbiter.sv
// Round-robin write/read access controller for the 200-word data memory.
// Every output is registered; the write and read strobes are never high together.
module mem_access_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address_dec,
  output logic [ADDR_W-1:0] mem_address_test,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rwn,
  output logic              mem_start,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_t;

  state_t state_r;
  grant_t last_grant_r;
  logic   grant_wr_s;
  logic   grant_rd_s;
  logic   wr_oor_s;
  logic   rd_oor_s;

  assign wr_oor_s = (wr_addr >= ADDR_W'(DEPTH));
  assign rd_oor_s = (rd_addr >= ADDR_W'(DEPTH));

  // Round-robin pick between the two requesters, favouring the one not served last.
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (wr_req && rd_req) begin
      if (last_grant_r == GNT_READ) begin
        grant_wr_s = 1'b1;
      end else begin
        grant_rd_s = 1'b1;
      end
    end else if (wr_req) begin
      grant_wr_s = 1'b1;
    end else if (rd_req) begin
      grant_rd_s = 1'b1;
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  // Access FSM with registered handshake, strobe and read-data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      last_grant_r     <= GNT_READ;
      wr_ack           <= 1'b0;
      rd_ack           <= 1'b0;
      rd_valid         <= 1'b0;
      rd_data          <= {DATA_W{1'b0}};
      err              <= 1'b0;
      busy             <= 1'b0;
      mem_address_dec  <= {ADDR_W{1'b0}};
      mem_address_test <= {ADDR_W{1'b0}};
      mem_data_in      <= {DATA_W{1'b0}};
      mem_rwn          <= 1'b0;
      mem_start        <= 1'b0;
    end else begin
      // Pulses and strobes default low; address/data registers hold.
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      mem_rwn   <= 1'b0;
      mem_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_wr_s) begin
            last_grant_r <= GNT_WRITE;
            wr_ack       <= 1'b1;
            busy         <= 1'b1;
            if (wr_oor_s) begin
              err     <= 1'b1;
              state_r <= ST_ERR;
            end else begin
              mem_address_dec <= wr_addr;
              mem_data_in     <= wr_data;
              mem_start       <= 1'b1;
              state_r         <= ST_WR;
            end
          end else if (grant_rd_s) begin
            last_grant_r <= GNT_READ;
            rd_ack       <= 1'b1;
            busy         <= 1'b1;
            if (rd_oor_s) begin
              err     <= 1'b1;
              state_r <= ST_ERR;
            end else begin
              mem_address_test <= rd_addr;
              mem_rwn          <= 1'b1;
              state_r          <= ST_RD;
            end
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WR: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_RD: begin
          busy    <= 1'b1;
          state_r <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          rd_data  <= mem_data_out;
          rd_valid <= 1'b1;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        ST_ERR: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized, self-checking bench for mem_access_arbiter against a transaction-level
// model: round-robin grant order, fixed per-access occupancy, and a shadow memory.
module tb_mem_access_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 200;

  logic          clk;
  logic          reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_ack, rd_valid, err, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_address_dec, mem_address_test;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_rwn, mem_start;

  logic [DW-1:0] tb_mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  bit            lg_write;
  int            n_checks;
  int            n_fail;

  mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .busy(busy),
    .mem_address_dec(mem_address_dec), .mem_address_test(mem_address_test),
    .mem_data_in(mem_data_in), .mem_rwn(mem_rwn), .mem_start(mem_start),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: writes on mem_start, read data valid the cycle after mem_rwn.
  always @(posedge clk) begin
    if (mem_start && mem_address_dec < AW'(DEPTH)) tb_mem[mem_address_dec] <= mem_data_in;
    if (mem_rwn) mem_data_out <= (mem_address_test < AW'(DEPTH)) ? tb_mem[mem_address_test] : 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 16'd0; rd_addr = 16'd0; wr_data = 32'h1234_5678;
    repeat (3) step();
    n_checks++;
    if ({wr_ack, rd_ack, rd_valid, err, busy, mem_rwn, mem_start} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {wr_ack, rd_ack, rd_valid, err, busy, mem_rwn, mem_start});
    end
    n_checks++;
    if ({mem_address_dec, mem_address_test, mem_data_in, rd_data} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: dec=%h test=%h din=%h rd_data=%h want 0", mem_address_dec, mem_address_test, mem_data_in, rd_data);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if ({wr_ack, rd_ack, mem_start, mem_rwn} !== 4'b1010) begin
      n_fail++; $display("FAIL first_grant: wr_ack,rd_ack,start,rwn=%b want 1010", {wr_ack, rd_ack, mem_start, mem_rwn});
    end
    wr_req = 1'b0; rd_req = 1'b0;
    exp_mem[0] = 32'h1234_5678; lg_write = 1'b1;
    step();
    n_checks++;
    if ({busy, mem_start, wr_ack} !== 3'b000) begin
      n_fail++; $display("FAIL first_grant_done: busy,start,ack=%b want 000", {busy, mem_start, wr_ack});
    end
  endtask

  task automatic test_write();
    wr_req = 1'b1; wr_addr = 16'd5; wr_data = 32'hDEAD_BEEF;
    step();
    n_checks++;
    if ({mem_start, wr_ack, mem_rwn, mem_address_dec, mem_data_in} !== {3'b110, 16'd5, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL write_issue: start=%b ack=%b rwn=%b dec=%0d din=%h want 1 1 0 5 deadbeef", mem_start, wr_ack, mem_rwn, mem_address_dec, mem_data_in);
    end
    wr_req = 1'b0;
    exp_mem[5] = 32'hDEAD_BEEF; lg_write = 1'b1;
    step();
    n_checks++;
    if ({mem_start, busy, wr_ack} !== 3'b000) begin
      n_fail++; $display("FAIL write_done: start,busy,ack=%b want 000", {mem_start, busy, wr_ack});
    end
  endtask

  task automatic test_read();
    rd_req = 1'b1; rd_addr = 16'd5;
    step();
    n_checks++;
    if ({rd_ack, mem_rwn, mem_start, rd_valid, mem_address_test} !== {4'b1100, 16'd5}) begin
      n_fail++; $display("FAIL read_issue: ack=%b rwn=%b start=%b valid=%b test=%0d want 1 1 0 0 5", rd_ack, mem_rwn, mem_start, rd_valid, mem_address_test);
    end
    rd_req = 1'b0; lg_write = 1'b0;
    step();
    n_checks++;
    if ({rd_ack, mem_rwn, rd_valid, busy} !== 4'b0001) begin
      n_fail++; $display("FAIL read_wait: ack,rwn,valid,busy=%b want 0001", {rd_ack, mem_rwn, rd_valid, busy});
    end
    step();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_mem[5]) begin
      n_fail++; $display("FAIL read_data: valid=%b data=%h want 1 %h", rd_valid, rd_data, exp_mem[5]);
    end
  endtask

  task automatic test_round_robin();
    int acks;
    bit prev_ack;
    acks = 0; prev_ack = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 16'd10; rd_addr = 16'd10; wr_data = 32'hC0FF_EE10;
    for (int c = 0; c < 20; c++) begin
      step();
      n_checks++;
      if (mem_rwn && mem_start) begin
        n_fail++; $display("FAIL rr_exclusive: cycle %0d rwn and start both high", c);
      end
      if (wr_ack || rd_ack) begin
        n_checks++;
        if (prev_ack || (wr_ack === rd_ack) || (wr_ack !== !lg_write)) begin
          n_fail++; $display("FAIL rr_order: cycle %0d wr_ack=%b rd_ack=%b prev=%b want wr_ack=%b", c, wr_ack, rd_ack, prev_ack, !lg_write);
        end
        lg_write = !lg_write;
        acks++;
      end
      if (rd_valid) begin
        n_checks++;
        if (rd_data !== 32'hC0FF_EE10) begin
          n_fail++; $display("FAIL rr_data: got %h want c0ffee10", rd_data);
        end
      end
      prev_ack = wr_ack | rd_ack;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    exp_mem[10] = 32'hC0FF_EE10;
    n_checks++;
    if (acks != 8) begin
      n_fail++; $display("FAIL rr_count: got %0d acks want 8", acks);
    end
    repeat (3) step();
  endtask

  task automatic test_errors();
    wr_req = 1'b1; wr_addr = 16'd200; wr_data = 32'h1111_1111;
    step();
    n_checks++;
    if ({wr_ack, err, mem_start, mem_rwn, busy} !== 5'b11001) begin
      n_fail++; $display("FAIL err_write: ack,err,start,rwn,busy=%b want 11001", {wr_ack, err, mem_start, mem_rwn, busy});
    end
    wr_req = 1'b0; lg_write = 1'b1;
    step();
    n_checks++;
    if ({wr_ack, err, busy} !== 3'b000) begin
      n_fail++; $display("FAIL err_clear: ack,err,busy=%b want 000", {wr_ack, err, busy});
    end
    rd_req = 1'b1; rd_addr = 16'hFFFF;
    step();
    n_checks++;
    if ({rd_ack, err, mem_start, mem_rwn} !== 4'b1100) begin
      n_fail++; $display("FAIL err_read: ack,err,start,rwn=%b want 1100", {rd_ack, err, mem_start, mem_rwn});
    end
    rd_req = 1'b0; lg_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (rd_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++; $display("FAIL err_no_valid: cycle %0d valid=%b err=%b want 0 0", c, rd_valid, err);
      end
    end
    wr_req = 1'b1; wr_addr = 16'd7; wr_data = 32'hA5A5_0007;
    step();
    wr_req = 1'b0; exp_mem[7] = 32'hA5A5_0007; lg_write = 1'b1;
    step();
    rd_req = 1'b1; rd_addr = 16'd7;
    step();
    rd_req = 1'b0; lg_write = 1'b0;
    repeat (2) step();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0007 || err !== 1'b0) begin
      n_fail++; $display("FAIL err_recover: valid=%b data=%h err=%b want 1 a5a50007 0", rd_valid, rd_data, err);
    end
  endtask

  task automatic test_random(input int cycles);
    int occupied, rv_cnt;
    logic [DW-1:0] rv_data;
    logic gw, gr, e_wack, e_rack, e_err, e_start, e_rwn, e_rv, e_busy;
    occupied = 0; rv_cnt = 0; rv_data = '0;
    wr_req = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1'b1;
        wr_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(200, 65535)) : AW'($urandom_range(0, 199));
        wr_data = $urandom;
      end
      if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_req = 1'b1;
        rd_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(200, 65535)) : AW'($urandom_range(0, 199));
      end
      {e_wack, e_rack, e_err, e_start, e_rwn, e_rv} = 6'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) e_rv = 1'b1;
      end
      if (occupied == 0) begin
        gw = wr_req && (!rd_req || !lg_write);
        gr = rd_req && !gw;
        if (gw) begin
          e_wack = 1'b1; lg_write = 1'b1; occupied = 1;
          if (wr_addr < AW'(DEPTH)) begin
            e_start = 1'b1; exp_mem[wr_addr] = wr_data;
          end else e_err = 1'b1;
        end else if (gr) begin
          e_rack = 1'b1; lg_write = 1'b0;
          if (rd_addr < AW'(DEPTH)) begin
            e_rwn = 1'b1; rv_cnt = 2; rv_data = exp_mem[rd_addr]; occupied = 2;
          end else begin
            e_err = 1'b1; occupied = 1;
          end
        end
      end else occupied--;
      e_busy = (occupied != 0);
      step();
      n_checks++;
      if ({wr_ack, rd_ack, err, mem_start, mem_rwn, rd_valid, busy} !== {e_wack, e_rack, e_err, e_start, e_rwn, e_rv, e_busy}) begin
        n_fail++; $display("FAIL rand_ctrl: cycle %0d wack,rack,err,start,rwn,valid,busy=%b want %b", c,
          {wr_ack, rd_ack, err, mem_start, mem_rwn, rd_valid, busy}, {e_wack, e_rack, e_err, e_start, e_rwn, e_rv, e_busy});
      end
      if (e_rv) begin
        n_checks++;
        if (rd_data !== rv_data) begin
          n_fail++; $display("FAIL rand_data: cycle %0d got %h want %h", c, rd_data, rv_data);
        end
      end
      if (e_wack) wr_req = 1'b0;
      if (e_rack) rd_req = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; rd_addr = 16'd5;
    step();
    rd_req = 1'b0;
    step();
    n_checks++;
    if ({busy, rd_valid, mem_rwn} !== 3'b100) begin
      n_fail++; $display("FAIL midrst_precond: busy,valid,rwn=%b want 100", {busy, rd_valid, mem_rwn});
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_ack, rd_ack, rd_valid, err, busy, mem_rwn, mem_start} !== 7'b0 || rd_data !== 32'h0 || mem_address_test !== 16'h0) begin
      n_fail++; $display("FAIL midrst_async: ctrl=%b rd_data=%h test=%h want 0", {wr_ack, rd_ack, rd_valid, err, busy, mem_rwn, mem_start}, rd_data, mem_address_test);
    end
    repeat (2) step();
    reset = 1'b1; lg_write = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midrst_quiet: cycle %0d valid=%b busy=%b want 0 0", c, rd_valid, busy);
      end
    end
    wr_req = 1'b1; wr_addr = 16'd3; wr_data = 32'h0BAD_F00D;
    step();
    n_checks++;
    if ({wr_ack, mem_start, mem_address_dec} !== {2'b11, 16'd3}) begin
      n_fail++; $display("FAIL midrst_resume: ack=%b start=%b dec=%0d want 1 1 3", wr_ack, mem_start, mem_address_dec);
    end
    wr_req = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; lg_write = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    mem_data_out = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_errors();
    test_random(600);
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
